// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt pending latch and the 2^N-to-N
// priority encoder it feeds.
//   irq_state_e   : service FSM states (IRQ_IDLE, IRQ_HOLD)
//   IRQ_N_DEFAULT : default encoder index width
//   width_of(n)   : request vector width for an n-bit index (2**n)
package irq_pkg;

    typedef enum logic [0:0] {
        IRQ_IDLE = 1'b0,
        IRQ_HOLD = 1'b1
    } irq_state_e;

    localparam int IRQ_N_DEFAULT = 3;

    function automatic int width_of(input int n);
        return 32'sd1 << n;
    endfunction

endpackage

// File: rtl/irq_edge_capture.sv
// Rising-edge detector for the raw request lines.
// Optional build macro: IRQ_REQ_SYNC_EN -- when defined, each request bit
// passes through a 2-flop synchroniser before edge detection.
// Ports:
//   clk     : clock, rising edge
//   rst     : asynchronous active-high reset
//   req_i   : raw request levels (W bits)
//   edges_o : one-cycle pulse per bit on a 0->1 transition of the
//             (optionally synchronised) request
module irq_edge_capture #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] req_i,
    output logic [W-1:0] edges_o
);

    logic [W-1:0] req_s;
    logic [W-1:0] req_prev_q;

`ifdef IRQ_REQ_SYNC_EN
    logic [W-1:0] sync1_q;
    logic [W-1:0] sync2_q;

    // Two-stage synchroniser for asynchronous request inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= req_i;
            sync2_q <= sync1_q;
        end
    end

    assign req_s = sync2_q;
`else
    assign req_s = req_i;
`endif

    // Previous request level; resets low so a line held high through reset
    // release is seen as a fresh edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_prev_q <= '0;
        end else begin
            req_prev_q <= req_s;
        end
    end

    assign edges_o = req_s & ~req_prev_q;

endmodule

// File: rtl/irq_pending_latch.sv
// Edge-captured, maskable interrupt pending latch feeding a 2^N-to-N
// priority encoder. While a claimed request is in service (HOLD) the vector
// presented to the encoder is frozen so its index/valid stay stable.
// Optional build macro: IRQ_REQ_SYNC_EN (adds 2-flop request synchroniser,
// edge-to-a_o latency becomes 3 cycles instead of 1).
// Ports:
//   clk, rst    : clock and asynchronous active-high reset
//   req_i       : raw request levels, rising edge raises a request
//   mask_i      : per-bit presentation enable (pending kept when masked)
//   claim_i     : snapshot current a_o and enter service
//   done_i      : service of done_idx_i complete, clear that pending bit
//   done_idx_i  : index of the bit to clear
//   a_o         : vector to encoder input
//   pending_o   : raw pending register
//   busy_o      : high while in service
//   overflow_o  : sticky, an edge hit an already-pending bit
module irq_pending_latch
    import irq_pkg::*;
#(
    parameter  int N = IRQ_N_DEFAULT,
    localparam int W = width_of(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] req_i,
    input  logic [W-1:0] mask_i,
    input  logic         claim_i,
    input  logic         done_i,
    input  logic [N-1:0] done_idx_i,
    output logic [W-1:0] a_o,
    output logic [W-1:0] pending_o,
    output logic         busy_o,
    output logic         overflow_o
);

    irq_state_e   state_q, state_d;
    logic [W-1:0] pending_q, pending_d;
    logic [W-1:0] snapshot_q, snapshot_d;
    logic         overflow_q, overflow_d;

    logic [W-1:0] edges_s;
    logic [W-1:0] clr_s;
    logic [W-1:0] visible_s;

    irq_edge_capture #(.W(W)) u_edge (
        .clk     (clk),
        .rst     (rst),
        .req_i   (req_i),
        .edges_o (edges_s)
    );

    assign visible_s = pending_q & mask_i;

    // Clear vector: completion is only honoured while in service.
    always_comb begin
        clr_s = '0;
        if ((state_q == IRQ_HOLD) && done_i) begin
            clr_s[done_idx_i] = 1'b1;
        end else begin
            clr_s = '0;
        end
    end

    // Pending/overflow next state; a same-cycle set beats a clear and is not
    // an overflow because the bit was being released.
    always_comb begin
        pending_d  = (pending_q & ~clr_s) | edges_s;
        overflow_d = overflow_q | (|(edges_s & pending_q & ~clr_s));
    end

    // Service FSM next state and snapshot capture.
    always_comb begin
        state_d    = state_q;
        snapshot_d = snapshot_q;
        case (state_q)
            IRQ_IDLE: begin
                if (claim_i && (visible_s != '0)) begin
                    snapshot_d = visible_s;
                    state_d    = IRQ_HOLD;
                end else begin
                    state_d    = IRQ_IDLE;
                end
            end
            IRQ_HOLD: begin
                if (done_i) begin
                    state_d = IRQ_IDLE;
                end else begin
                    state_d = IRQ_HOLD;
                end
            end
            default: begin
                state_d = IRQ_IDLE;
            end
        endcase
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IRQ_IDLE;
            pending_q  <= '0;
            snapshot_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            snapshot_q <= snapshot_d;
            overflow_q <= overflow_d;
        end
    end

    // a_o follows pending & mask with no register delay in IDLE so a
    // completed request's successor appears one cycle after done_i.
    assign a_o        = (state_q == IRQ_HOLD) ? snapshot_q : visible_s;
    assign pending_o  = pending_q;
    assign busy_o     = (state_q == IRQ_HOLD);
    assign overflow_o = overflow_q;

endmodule
